// File: rtl/l2_mem_req_bridge_if.sv
`default_nettype none
// ============================================================================
// Module      : UNICAD_MEM_BUS_64
// Description : 64-bit single-port SRAM bus. Master drives the strobes,
//               address, byte enables and write data. Slave returns read
//               data the cycle after a read strobe.
// Revision    : 1.0 - initial release
// ============================================================================
interface UNICAD_MEM_BUS_64 #(
    parameter int ADDR_W = 12
);
    logic              csn;    // chip select, active-low
    logic              wen;    // write enable, active-low
    logic [7:0]        be;     // byte enables, active-high
    logic [ADDR_W-1:0] add;    // word address
    logic [63:0]       wdata;
    logic [63:0]       rdata;

    modport Master (output csn, wen, be, add, wdata, input rdata);
    modport Slave  (input csn, wen, be, add, wdata, output rdata);
endinterface
`default_nettype wire

// File: rtl/l2_mem_req_bridge.sv
`default_nettype none
// ============================================================================
// Module      : l2_mem_req_bridge
// Description : Initiator-side adapter from a req/gnt request channel and a
//               valid/ready response channel onto the 64-bit L2 SRAM bus.
//               Absorbs the 1-cycle SRAM read latency and buffers responses
//               in a RESP_DEPTH-entry FIFO so backpressure never drops data.
//               Optional macro L2_MEM_ZERO_INIT_EN: after reset, zero-fill the
//               whole SRAM before accepting requests.
// Revision    : 1.0 - initial release
// ============================================================================
module l2_mem_req_bridge #(
    parameter int MEM_ADDR_WIDTH = 12,
    parameter int ADDR_WIDTH     = 32,
    parameter int RESP_DEPTH     = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  req_i,
    output logic                  gnt_o,
    input  logic                  we_i,
    input  logic [7:0]            be_i,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic [63:0]           wdata_i,
    output logic                  rvalid_o,
    input  logic                  rready_i,
    output logic [63:0]           rdata_o,
    output logic                  rwr_o,
    output logic                  init_done_o,
    UNICAD_MEM_BUS_64.Master      mem_master
);

    localparam int                PTR_W     = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;
    localparam int                CNT_W     = $clog2(RESP_DEPTH + 1);
    localparam logic [PTR_W-1:0]  LAST_PTR  = PTR_W'(RESP_DEPTH - 1);
    localparam logic [CNT_W:0]    DEPTH_EXT = (CNT_W + 1)'(RESP_DEPTH);
    localparam logic [CNT_W-1:0]  FULL_CNT  = CNT_W'(RESP_DEPTH);

    // Response FIFO state
    logic [63:0]           r_fifo_data [RESP_DEPTH];
    logic [RESP_DEPTH-1:0] r_fifo_wr;
    logic [PTR_W-1:0]      r_wr_ptr;
    logic [PTR_W-1:0]      r_rd_ptr;
    logic [CNT_W-1:0]      r_cnt;

    // Access issued to the SRAM last cycle; its read data is on the bus now
    logic                  r_inflight;
    logic                  r_wr_q;

    logic                  w_run;        // bridge may grant requests
    logic                  w_init_wr;    // zero-fill write active this cycle
    logic [MEM_ADDR_WIDTH-1:0] w_init_addr;
    logic                  w_push;
    logic                  w_pop;
    logic [CNT_W:0]        w_used;       // credits held after this cycle's pop

    function automatic logic [PTR_W-1:0] f_next_ptr(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + {{(PTR_W-1){1'b0}}, 1'b1};
    endfunction

`ifdef L2_MEM_ZERO_INIT_EN
    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t                    r_state;
    logic [MEM_ADDR_WIDTH-1:0] r_init_addr;
    logic                      r_init_done;

    // Zero-fill sequencer: one word per cycle, then RUN until the next reset
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state     <= ST_INIT;
            r_init_addr <= '0;
            r_init_done <= 1'b0;
        end else begin
            case (r_state)
                ST_INIT: begin
                    r_init_addr <= r_init_addr + {{(MEM_ADDR_WIDTH-1){1'b0}}, 1'b1};
                    if (&r_init_addr) begin
                        r_state     <= ST_RUN;
                        r_init_done <= 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_RUN;
                end
            endcase
        end
    end

    // Reset is folded in so the SRAM sees an idle bus while rst_ni is low
    assign w_init_wr   = rst_ni && (r_state == ST_INIT);
    assign w_run       = rst_ni && (r_state == ST_RUN);
    assign w_init_addr = r_init_addr;
    assign init_done_o = r_init_done;
`else
    assign w_init_wr   = 1'b0;
    assign w_run       = rst_ni;
    assign w_init_addr = '0;
    assign init_done_o = 1'b1;
`endif

    // Credit check: buffered + in flight, less what leaves this cycle
    assign w_pop  = rvalid_o && rready_i;
    assign w_push = r_inflight;
    assign w_used = {1'b0, r_cnt}
                  + {{CNT_W{1'b0}}, r_inflight}
                  - {{CNT_W{1'b0}}, w_pop};
    assign gnt_o  = w_run && req_i && (w_used < DEPTH_EXT);

    // SRAM drive; wen is held high whenever no write is actually strobed
    assign mem_master.csn   = w_init_wr ? 1'b0  : ~gnt_o;
    assign mem_master.wen   = w_init_wr ? 1'b0  : ~(gnt_o & we_i);
    assign mem_master.be    = w_init_wr ? 8'hFF : be_i;
    assign mem_master.wdata = w_init_wr ? 64'h0 : wdata_i;
    assign mem_master.add   = w_init_wr ? w_init_addr : addr_i[MEM_ADDR_WIDTH+2:3];

    // Response head comes straight from FIFO registers
    assign rvalid_o = (r_cnt != '0);
    assign rdata_o  = r_fifo_data[r_rd_ptr];
    assign rwr_o    = r_fifo_wr[r_rd_ptr];

    // In-flight tracking, response capture and FIFO pointer/count update
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_inflight <= 1'b0;
            r_wr_q     <= 1'b0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_cnt      <= '0;
            r_fifo_wr  <= '0;
            for (int i = 0; i < RESP_DEPTH; i++) begin
                r_fifo_data[i] <= '0;
            end
        end else begin
            r_inflight <= gnt_o;
            r_wr_q     <= we_i;
            if (w_push) begin
                r_fifo_data[r_wr_ptr] <= r_wr_q ? 64'h0 : mem_master.rdata;
                r_fifo_wr[r_wr_ptr]   <= r_wr_q;
                r_wr_ptr              <= f_next_ptr(r_wr_ptr);
            end
            if (w_pop) begin
                r_rd_ptr <= f_next_ptr(r_rd_ptr);
            end
            case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
                2'b01:   r_cnt <= r_cnt - {{(CNT_W-1){1'b0}}, 1'b1};
                default: r_cnt <= r_cnt;
            endcase
        end
    end

`ifndef SYNTHESIS
    // Simulation-only checks of FIFO occupancy and configuration
    always_ff @(posedge clk_i) begin
        if (rst_ni) begin
            assert (!(w_push && (r_cnt == FULL_CNT)))
                else $error("l2_mem_req_bridge: push into full response FIFO");
            assert (!(w_pop && (r_cnt == '0)))
                else $error("l2_mem_req_bridge: pop from empty response FIFO");
            assert (RESP_DEPTH >= 2)
                else $error("l2_mem_req_bridge: RESP_DEPTH must be at least 2");
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_l2_mem_req_bridge.sv
`default_nettype none
// ============================================================================
// Module      : tb_l2_mem_req_bridge
// Description : Directed self-checking bench for l2_mem_req_bridge with a
//               behavioural 1-cycle-latency SRAM on the memory bus.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_l2_mem_req_bridge;

    localparam int MAW    = 12;
    localparam int AW     = 32;
    localparam int DEPTH  = 2;
    localparam int NWORDS = 1 << MAW;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req;
    logic        we;
    logic [7:0]  be;
    logic [31:0] addr;
    logic [63:0] wdata;
    logic        rready;
    logic        gnt;
    logic        rvalid;
    logic [63:0] rdata;
    logic        rwr;
    logic        init_done;

    int checks   = 0;
    int failures = 0;

    logic [63:0] mem_arr [NWORDS];   // SRAM model storage
    logic [63:0] exp_mem [NWORDS];   // bench's own view of memory contents

    UNICAD_MEM_BUS_64 #(.ADDR_W(MAW)) mem_bus ();

    l2_mem_req_bridge #(
        .MEM_ADDR_WIDTH (MAW),
        .ADDR_WIDTH     (AW),
        .RESP_DEPTH     (DEPTH)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .req_i       (req),
        .gnt_o       (gnt),
        .we_i        (we),
        .be_i        (be),
        .addr_i      (addr),
        .wdata_i     (wdata),
        .rvalid_o    (rvalid),
        .rready_i    (rready),
        .rdata_o     (rdata),
        .rwr_o       (rwr),
        .init_done_o (init_done),
        .mem_master  (mem_bus.Master)
    );

    always #5 clk = ~clk;

    // SRAM model: byte-masked writes, read data one cycle after the strobe
    always @(posedge clk) begin
        if (mem_bus.csn === 1'b0) begin
            if (mem_bus.wen === 1'b0) begin
                for (int b = 0; b < 8; b++) begin
                    if (mem_bus.be[b]) mem_arr[mem_bus.add][b*8 +: 8] <= mem_bus.wdata[b*8 +: 8];
                end
            end else begin
                mem_bus.rdata <= mem_arr[mem_bus.add];
            end
        end
    end

    initial begin
        for (int i = 0; i < NWORDS; i++) mem_arr[i] <= 64'hC0DE_0000_0000_0000 | 64'(i);
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic idle_inputs();
        req = 1'b0; we = 1'b0; be = 8'h00; addr = 32'h0; wdata = 64'h0;
    endtask

    task automatic drive(input logic r, input logic w, input logic [31:0] a,
                         input logic [63:0] d, input logic [7:0] b);
        req = r; we = w; addr = a; wdata = d; be = b;
    endtask

    // Wait out the post-reset phase and check when the bridge comes up
    task automatic wait_init();
`ifdef L2_MEM_ZERO_INIT_EN
        int bad_gnt = 0;
        int rise_at = -1;
        drive(1'b1, 1'b0, 32'h0, 64'h0, 8'hFF);
        for (int k = 1; k <= NWORDS; k++) begin
            @(negedge clk); #1;
            if (k < NWORDS) begin
                if (gnt !== 1'b0) bad_gnt++;
                if (init_done !== 1'b0 && rise_at < 0) rise_at = k;
            end else begin
                if (init_done === 1'b1 && rise_at < 0) rise_at = k;
                req = 1'b0;
            end
        end
        checks++;
        if (bad_gnt != 0) begin
            failures++;
            $display("FAIL init_gnt: gnt_o high %0d times during INIT, expected 0", bad_gnt);
        end
        checks++;
        if (rise_at != NWORDS) begin
            failures++;
            $display("FAIL init_done_timing: rose at cycle %0d, expected %0d", rise_at, NWORDS);
        end
        for (int i = 0; i < NWORDS; i++) exp_mem[i] = 64'h0;
`else
        @(negedge clk); #1;
        checks++;
        if (init_done !== 1'b1) begin
            failures++;
            $display("FAIL init_done_const: got %b expected 1", init_done);
        end
`endif
        idle_inputs();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; rready = 1'b0; idle_inputs();
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if (gnt !== 1'b0) begin failures++; $display("FAIL rst_gnt: got %b expected 0", gnt); end
        checks++;
        if (rvalid !== 1'b0) begin failures++; $display("FAIL rst_rvalid: got %b expected 0", rvalid); end
        checks++;
        if (rdata !== 64'h0) begin failures++; $display("FAIL rst_rdata: got %h expected 0", rdata); end
        checks++;
        if (rwr !== 1'b0) begin failures++; $display("FAIL rst_rwr: got %b expected 0", rwr); end
        checks++;
        if (mem_bus.csn !== 1'b1 || mem_bus.wen !== 1'b1) begin
            failures++;
            $display("FAIL rst_mem_idle: csn=%b wen=%b expected csn=1 wen=1", mem_bus.csn, mem_bus.wen);
        end
        // A request held during reset must not be granted nor reach the SRAM
        drive(1'b1, 1'b1, 32'h40, 64'h1, 8'hFF);
        #1;
        checks++;
        if (gnt !== 1'b0 || mem_bus.csn !== 1'b1 || mem_bus.wen !== 1'b1) begin
            failures++;
            $display("FAIL rst_req_blocked: gnt=%b csn=%b wen=%b expected 0 1 1", gnt, mem_bus.csn, mem_bus.wen);
        end
        idle_inputs();
        @(negedge clk);
        rst_n = 1'b1;
        wait_init();
    endtask

    task automatic test_back_to_back();
        rready = 1'b1;
        @(negedge clk);
        drive(1'b1, 1'b1, 32'h40, 64'hDEADBEEF_01234567, 8'hFF); #1;
        checks++;
        if (gnt !== 1'b1 || rvalid !== 1'b0) begin
            failures++; $display("FAIL b2b_wr_gnt: gnt=%b rvalid=%b expected 1 0", gnt, rvalid);
        end
        exp_mem[8] = 64'hDEADBEEF_01234567;
        @(negedge clk);
        drive(1'b1, 1'b0, 32'h40, 64'h0, 8'hFF); #1;
        checks++;
        if (gnt !== 1'b1 || rvalid !== 1'b0) begin
            failures++; $display("FAIL b2b_rd_gnt: gnt=%b rvalid=%b expected 1 0", gnt, rvalid);
        end
        @(negedge clk);
        idle_inputs(); #1;
        checks++;
        if (rvalid !== 1'b1 || rwr !== 1'b1 || rdata !== 64'h0) begin
            failures++;
            $display("FAIL b2b_wr_resp: v=%b wr=%b d=%h expected 1 1 0", rvalid, rwr, rdata);
        end
        @(negedge clk); #1;
        checks++;
        if (rvalid !== 1'b1 || rwr !== 1'b0 || rdata !== 64'hDEADBEEF_01234567) begin
            failures++;
            $display("FAIL b2b_rd_resp: v=%b wr=%b d=%h expected 1 0 deadbeef01234567", rvalid, rwr, rdata);
        end
        @(negedge clk); #1;
        checks++;
        if (rvalid !== 1'b0) begin failures++; $display("FAIL b2b_drain: rvalid=%b expected 0", rvalid); end
    endtask

    task automatic test_backpressure();
        logic [63:0] e0, e1, e2;
        e0 = exp_mem[0]; e1 = exp_mem[1]; e2 = exp_mem[2];
        rready = 1'b0;
        @(negedge clk);
        drive(1'b1, 1'b0, 32'h0, 64'h0, 8'hFF); #1;
        checks++;
        if (gnt !== 1'b1) begin failures++; $display("FAIL bp_gnt0: gnt=%b expected 1", gnt); end
        @(negedge clk);
        drive(1'b1, 1'b0, 32'h8, 64'h0, 8'hFF); #1;
        checks++;
        if (gnt !== 1'b1) begin failures++; $display("FAIL bp_gnt1: gnt=%b expected 1", gnt); end
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            drive(1'b1, 1'b0, 32'h10, 64'h0, 8'hFF); #1;
            checks++;
            if (gnt !== 1'b0 || rvalid !== 1'b1 || rdata !== e0) begin
                failures++;
                $display("FAIL bp_stall%0d: gnt=%b v=%b d=%h expected 0 1 %h", c, gnt, rvalid, rdata, e0);
            end
        end
        @(negedge clk);
        rready = 1'b1; #1;
        checks++;
        if (gnt !== 1'b1 || rvalid !== 1'b1 || rdata !== e0) begin
            failures++;
            $display("FAIL bp_release: gnt=%b v=%b d=%h expected 1 1 %h", gnt, rvalid, rdata, e0);
        end
        @(negedge clk);
        idle_inputs(); #1;
        checks++;
        if (rvalid !== 1'b1 || rwr !== 1'b0 || rdata !== e1) begin
            failures++; $display("FAIL bp_resp1: v=%b wr=%b d=%h expected 1 0 %h", rvalid, rwr, rdata, e1);
        end
        @(negedge clk); #1;
        checks++;
        if (rvalid !== 1'b1 || rwr !== 1'b0 || rdata !== e2) begin
            failures++; $display("FAIL bp_resp2: v=%b wr=%b d=%h expected 1 0 %h", rvalid, rwr, rdata, e2);
        end
        @(negedge clk); #1;
        checks++;
        if (rvalid !== 1'b0) begin failures++; $display("FAIL bp_drain: rvalid=%b expected 0", rvalid); end
    endtask

    task automatic test_byte_enables();
        int gnt_miss = 0;
        rready = 1'b1;
        @(negedge clk);
        drive(1'b1, 1'b1, 32'h18, 64'hFFFFFFFF_FFFFFFFF, 8'hFF); #1;
        if (gnt !== 1'b1) gnt_miss++;
        @(negedge clk);
        drive(1'b1, 1'b1, 32'h18, 64'h0, 8'h0F); #1;
        if (gnt !== 1'b1) gnt_miss++;
        @(negedge clk);
        drive(1'b1, 1'b0, 32'h18, 64'h0, 8'hFF); #1;
        if (gnt !== 1'b1) gnt_miss++;
        checks++;
        if (gnt_miss != 0) begin failures++; $display("FAIL be_gnts: %0d of 3 not granted, expected 0", gnt_miss); end
        checks++;
        if (rvalid !== 1'b1 || rwr !== 1'b1 || rdata !== 64'h0) begin
            failures++; $display("FAIL be_wr1_resp: v=%b wr=%b d=%h expected 1 1 0", rvalid, rwr, rdata);
        end
        @(negedge clk);
        idle_inputs(); #1;
        checks++;
        if (rvalid !== 1'b1 || rwr !== 1'b1 || rdata !== 64'h0) begin
            failures++; $display("FAIL be_wr2_resp: v=%b wr=%b d=%h expected 1 1 0", rvalid, rwr, rdata);
        end
        @(negedge clk); #1;
        checks++;
        if (rvalid !== 1'b1 || rwr !== 1'b0 || rdata !== 64'hFFFFFFFF_00000000) begin
            failures++;
            $display("FAIL be_rd_resp: v=%b wr=%b d=%h expected 1 0 ffffffff00000000", rvalid, rwr, rdata);
        end
        exp_mem[3] = 64'hFFFFFFFF_00000000;
        @(negedge clk); #1;
    endtask

    task automatic test_streaming();
        rready = 1'b1;
        for (int k = 0; k < 18; k++) begin
            @(negedge clk);
            if (k < 16) drive(1'b1, 1'b0, 32'h100 + 32'(8 * k), 64'h0, 8'hFF);
            else        idle_inputs();
            #1;
            if (k < 16) begin
                checks++;
                if (gnt !== 1'b1) begin failures++; $display("FAIL stream_gnt%0d: gnt=%b expected 1", k, gnt); end
            end
            if (k >= 2) begin
                checks++;
                if (rvalid !== 1'b1 || rwr !== 1'b0 || rdata !== exp_mem[32 + k - 2]) begin
                    failures++;
                    $display("FAIL stream_resp%0d: v=%b wr=%b d=%h expected 1 0 %h",
                             k - 2, rvalid, rwr, rdata, exp_mem[32 + k - 2]);
                end
            end
        end
        @(negedge clk); #1;
        checks++;
        if (rvalid !== 1'b0) begin failures++; $display("FAIL stream_drain: rvalid=%b expected 0", rvalid); end
    endtask

    task automatic test_reset_mid_op();
        int stale = 0;
        logic [63:0] e8;
        rready = 1'b0;
        @(negedge clk);
        drive(1'b1, 1'b0, 32'h20, 64'h0, 8'hFF); #1;
        checks++;
        if (gnt !== 1'b1) begin failures++; $display("FAIL rmo_gnt0: gnt=%b expected 1", gnt); end
        @(negedge clk);
        drive(1'b1, 1'b0, 32'h28, 64'h0, 8'hFF); #1;
        checks++;
        if (gnt !== 1'b1) begin failures++; $display("FAIL rmo_gnt1: gnt=%b expected 1", gnt); end
        @(negedge clk);
        idle_inputs(); #1;
        checks++;
        if (rvalid !== 1'b1) begin failures++; $display("FAIL rmo_pre: rvalid=%b expected 1", rvalid); end
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if (rvalid !== 1'b0 || rdata !== 64'h0 || rwr !== 1'b0 || gnt !== 1'b0) begin
            failures++;
            $display("FAIL rmo_async: v=%b d=%h wr=%b gnt=%b expected 0 0 0 0", rvalid, rdata, rwr, gnt);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        wait_init();
        rready = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk); #1;
            if (rvalid !== 1'b0) stale++;
        end
        checks++;
        if (stale != 0) begin failures++; $display("FAIL rmo_stale: %0d stale responses, expected 0", stale); end
        // The bridge must be fully usable after the reset
        e8 = exp_mem[8];
        @(negedge clk);
        drive(1'b1, 1'b0, 32'h40, 64'h0, 8'hFF); #1;
        checks++;
        if (gnt !== 1'b1) begin failures++; $display("FAIL rmo_post_gnt: gnt=%b expected 1", gnt); end
        @(negedge clk);
        idle_inputs();
        @(negedge clk); #1;
        checks++;
        if (rvalid !== 1'b1 || rwr !== 1'b0 || rdata !== e8) begin
            failures++; $display("FAIL rmo_post_rd: v=%b wr=%b d=%h expected 1 0 %h", rvalid, rwr, rdata, e8);
        end
        @(negedge clk); #1;
        checks++;
        if (rvalid !== 1'b0) begin failures++; $display("FAIL rmo_post_drain: rvalid=%b expected 0", rvalid); end
    endtask

    initial begin
        rst_n  = 1'b0;
        rready = 1'b0;
        idle_inputs();
        for (int i = 0; i < NWORDS; i++) exp_mem[i] = 64'hC0DE_0000_0000_0000 | 64'(i);
        test_reset();
        test_back_to_back();
        test_backpressure();
        test_byte_enables();
        test_streaming();
        test_reset_mid_op();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
